// File: rtl/shift_unit_seq.sv
// Iterative shifter: SLL/SRL/SRA/ROR, at most MAX_STEP bits per clock.
// Valid/ready on request and result sides; result held until consumed.
module shift_unit_seq #(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    output logic             alu_valid_o,
    input  logic             alu_ready_i,
    output logic [WIDTH-1:0] alu_p_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0010;
    localparam logic [3:0] OP_SRA = 4'b0011;
    localparam logic [3:0] OP_ROR = 4'b0100;

    localparam logic [SHW-1:0] MAX_S   = SHW'(MAX_STEP);
    localparam logic [SHW:0]   WIDTH_E = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_d;
    logic [3:0]       op_q;
    logic [SHW-1:0]   rem_q;
    logic [SHW-1:0]   rem_d;
    logic [SHW-1:0]   step;
    logic             sign_q;
    logic [SHW:0]     ror_back;
    logic [WIDTH-1:0] fill_mask;
    logic             unused_b;

    // Upper shift-amount bits are deliberately ignored (amount mod WIDTH).
    assign unused_b = ^alu_b_i[WIDTH-1:SHW];

    // Clamp this cycle's step to the per-clock shift limit.
    always_comb begin
        step  = (rem_q > MAX_S) ? MAX_S : rem_q;
        rem_d = rem_q - step;
    end

    // One shift step of the working register; the sign comes from capture.
    always_comb begin
        w_d       = w_q;
        ror_back  = WIDTH_E - {1'b0, step};
        fill_mask = ~({WIDTH{1'b1}} >> step);
        case (op_q)
            OP_SLL:  w_d = w_q << step;
            OP_SRL:  w_d = w_q >> step;
            OP_SRA:  w_d = (w_q >> step) | (sign_q ? fill_mask : '0);
            OP_ROR:  w_d = (w_q >> step) | (w_q << ror_back);
            default: w_d = w_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (alu_valid_i) state_d = BUSY;
            BUSY: if (rem_d == '0) state_d = DONE;
            DONE: if (alu_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q    <= '0;
            op_q   <= '0;
            rem_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alu_valid_i) begin
                        w_q    <= alu_a_i;
                        op_q   <= alu_op_i;
                        rem_q  <= alu_b_i[SHW-1:0];
                        sign_q <= alu_a_i[WIDTH-1];
                    end
                end
                BUSY: begin
                    w_q   <= w_d;
                    rem_q <= rem_d;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registers.
    assign alu_ready_o = (state_q == IDLE);
    assign alu_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign alu_p_o     = w_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq at WIDTH=32, MAX_STEP=8.
// Checks results, latency, backpressure and asynchronous reset.
module tb_shift_unit_seq;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] p;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          n;
    } vec_t;

    vec_t vecs[14];

    shift_unit_seq #(
        .WIDTH(32),
        .MAX_STEP(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .alu_valid_i(valid_i),
        .alu_ready_o(ready_o),
        .alu_op_i   (op),
        .alu_a_i    (a),
        .alu_b_i    (b),
        .alu_valid_o(valid_o),
        .alu_ready_i(ready_i),
        .alu_p_o    (p),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Issue one request, measure latency, check result, then hand off.
    task automatic run(input vec_t v);
        int k;
        @(negedge clk);
        chk({v.name, " ready_o"}, {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        op      = v.op;
        a       = v.a;
        b       = v.b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        a       = 32'hDEAD_0000;
        b       = 32'h0000_001F;
        k = 1;
        @(posedge clk);
        #1;
        while (!valid_o && k < 20) begin
            k++;
            @(posedge clk);
            #1;
        end
        chk({v.name, " latency"}, k, v.n);
        chk({v.name, " result"}, p, v.exp);
        chk({v.name, " busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk({v.name, " valid drop"}, {31'd0, valid_o}, 32'd0);
        chk({v.name, " idle ready"}, {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        op      = 4'd0;
        a       = '0;
        b       = '0;

        vecs[0]  = '{"sra_b4",   4'b0011, 32'h8000_0000, 32'd4,  32'hF800_0000, 1};
        vecs[1]  = '{"srl_b31",  4'b0010, 32'h8000_0000, 32'd31, 32'h0000_0001, 4};
        vecs[2]  = '{"sll_mask", 4'b0001, 32'h0000_0001, 32'h25, 32'h0000_0020, 1};
        vecs[3]  = '{"sll_b0",   4'b0001, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1};
        vecs[4]  = '{"ror_b8",   4'b0100, 32'h1234_5678, 32'd8,  32'h7812_3456, 1};
        vecs[5]  = '{"ror_b20",  4'b0100, 32'h1234_5678, 32'd20, 32'h4567_8123, 3};
        vecs[6]  = '{"bad_op",   4'b1000, 32'h1234_5678, 32'd17, 32'h1234_5678, 3};
        vecs[7]  = '{"sra_neg",  4'b0011, 32'h8000_0001, 32'd31, 32'hFFFF_FFFF, 4};
        vecs[8]  = '{"sra_pos",  4'b0011, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000, 4};
        vecs[9]  = '{"sll_b16",  4'b0001, 32'h8000_0001, 32'd16, 32'h0001_0000, 2};
        vecs[10] = '{"srl_b9",   4'b0010, 32'hF0F0_F0F0, 32'd9,  32'h0078_7878, 2};
        vecs[11] = '{"ror_b31",  4'b0100, 32'h0000_0001, 32'd31, 32'h0000_0002, 4};
        vecs[12] = '{"sra_b8",   4'b0011, 32'h8F00_0000, 32'd8,  32'hFF8F_0000, 1};
        vecs[13] = '{"ror_b32",  4'b0100, 32'hA5A5_A5A5, 32'd32, 32'hA5A5_A5A5, 1};

        #12;
        chk("rst valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst p", p, 32'd0);
        chk("rst ready_o", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(vecs[i]);

        // Backpressure: result must hold while inputs churn.
        @(negedge clk);
        valid_i = 1'b1;
        op      = 4'b0001;
        a       = 32'h0000_0003;
        b       = 32'd2;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("bp valid", {31'd0, valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = i[0];
            op      = 4'b0010;
            a       = 32'hFFFF_0000 + i;
            b       = i;
            @(posedge clk);
            #1;
            chk("bp p", p, 32'h0000_000C);
            chk("bp valid_o", {31'd0, valid_o}, 32'd1);
            chk("bp ready_o", {31'd0, ready_o}, 32'd0);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp idle ready", {31'd0, ready_o}, 32'd1);
        chk("bp idle valid", {31'd0, valid_o}, 32'd0);
        chk("bp no capture", p, 32'h0000_000C);
        @(negedge clk);
        ready_i = 1'b0;

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        valid_i = 1'b1;
        op      = 4'b0010;
        a       = 32'h8000_0000;
        b       = 32'd31;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk);
        #2;
        chk("mid busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst valid_o", {31'd0, valid_o}, 32'd0);
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst p", p, 32'd0);
        chk("arst ready_o", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run(vecs[4]);
        run(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised, sequential successor to the team's combinational 32-bit right shifter.
- Supports four modes: logical left, logical right, arithmetic right and rotate right, at any power-of-two datapath width.
- Shifts iteratively, at most MAX_STEP bit positions per clock, so latency depends on the shift amount. This keeps area small for low-cost ALU configurations.
- Sits behind the ALU issue logic. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: datapath width. Power of two, >= 8.
- MAX_STEP, 8: maximum bit positions shifted per clock. Range 1..WIDTH-1.
- SHW (localparam), $clog2(WIDTH): number of shift-amount bits used.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- alu_valid_i  in  1  request valid.
- alu_ready_o  out  1  request ready. High only in IDLE.
- alu_op_i  in  4  mode: 4'b0001 SLL, 4'b0010 SRL, 4'b0011 SRA, 4'b0100 ROR. All other codes pass operand A through.
- alu_a_i  in  WIDTH  operand to shift.
- alu_b_i  in  WIDTH  shift amount. Only bits [SHW-1:0] are used; upper bits are ignored.
- alu_valid_o  out  1  result valid.
- alu_ready_i  in  1  result consumer ready.
- alu_p_o  out  WIDTH  result.
- busy_o  out  1  high in BUSY or DONE.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - State becomes IDLE and all internal registers clear.
  - alu_valid_o=0, busy_o=0, alu_p_o=0, alu_ready_o=1.
  - Takes effect immediately, including mid-operation. Any in-flight result is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - alu_ready_o=1.
  - On an edge with alu_valid_i=1, capture into registers: operand A (working register W), op, and rem = alu_b_i[SHW-1:0]. Go to BUSY.
- BUSY:
  - Each edge: step = min(rem, MAX_STEP). W is shifted by step per op; rem -= step.
  - When rem-after-step == 0, go to DONE on that edge.
  - rem==0 at capture still spends exactly one BUSY cycle (step 0).
  - BUSY cycles: N = max(1, ceil(shamt/MAX_STEP)).
- Shift rules, all per step, all within WIDTH:
  - SLL: zero fill at the LSB end.
  - SRL: zero fill at the MSB end.
  - SRA: fill with the captured A[WIDTH-1]. The sign stays constant across steps.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - Unsupported op: W unchanged. Still takes N cycles computed from rem.
- DONE:
  - alu_valid_o=1, alu_p_o=W.
  - Result, valid and all state held stable while alu_ready_i=0 (unbounded backpressure).
  - On an edge with alu_ready_i=1, go to IDLE and drop alu_valid_o.
  - alu_ready_o=0 in DONE; no same-cycle handoff and accept.
- Timing:
  - alu_valid_o rises N clocks after the acceptance edge.
  - Minimum request-to-request spacing is N+2 clocks.
- Inputs:
  - alu_valid_i and operand changes outside IDLE are ignored.
  - Operands are sampled only at the acceptance edge; changing them afterwards has no effect.
- alu_p_o outside DONE:
  - Shows W: the last delivered result, or 0 after reset.
  - Not meaningful without alu_valid_o.
- All outputs are registered. No combinational path from inputs to outputs.
- Shift amount is taken modulo WIDTH through the SHW-bit mask. Shift amount WIDTH-1 is the maximum.

Test Plan (WIDTH=32, MAX_STEP=8):
- SRA, a=0x80000000, b=4: accepted edge T, alu_valid_o high from T+1, alu_p_o=0xF8000000.
- SRL, a=0x80000000, b=31: result 0x00000001 after 4 BUSY cycles (valid at T+4). busy_o high from T+1 until handoff.
- SLL, a=0x00000001, b=0x25: upper bits ignored, shamt=5, result 0x00000020 at T+1. Separately, SLL with b=0: result=a at T+1.
- ROR, a=0x12345678, b=8: 0x78123456 at T+1. ROR same a, b=20: 0x45678123 at T+3. Op 4'b1000, b=17: result 0x12345678 at T+3.
- Backpressure: hold alu_ready_i=0 for 5 cycles in DONE while toggling alu_valid_i and operands. Required: alu_p_o, alu_valid_o=1 and alu_ready_o=0 stable, no new capture. Raise alu_ready_i: IDLE next cycle, alu_ready_o=1.
- Reset mid-BUSY: during SRL b=31, pull rst_ni low between edges. Required: alu_valid_o=0, busy_o=0, alu_p_o=0 without waiting for a clock edge. After release, ready_o=1 and the next request completes correctly.
